// File: rtl/xgriscv_memarb.sv
// Shared single-port memory arbiter for the xgriscv IF and MEM stages; one access in flight.
// Optional XGRISCV_ARB_RR_EN: round-robin tie-break instead of fixed data-over-fetch priority.
module xgriscv_memarb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       owner_q;  // 1 = data, 0 = fetch
  logic       we_q;
  logic       pick_data;

`ifdef XGRISCV_ARB_RR_EN
  logic last_q;  // owner of the most recent issue, 1 = data

  always_comb begin
    pick_data = d_req && !(i_req && last_q);
  end
`else
  always_comb begin
    pick_data = d_req;
  end
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= 4'd0;
`ifdef XGRISCV_ARB_RR_EN
      last_q   <= 1'b0;
`endif
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            state_q <= StIssue;
            owner_q <= pick_data;
            m_en    <= 1'b1;
            if (pick_data) begin
              d_gnt   <= 1'b1;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
              m_we    <= d_we;
              we_q    <= d_we;
            end else begin
              // Fetches are reads; store-only fields keep their last value.
              i_gnt  <= 1'b1;
              m_addr <= i_addr;
              we_q   <= 1'b0;
            end
          end
        end
        StIssue: begin
`ifdef XGRISCV_ARB_RR_EN
          last_q <= owner_q;
`endif
          if (we_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= 4'(MEM_LAT);
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            if (owner_q) begin
              d_rdata  <= m_rdata;
              d_rvalid <= 1'b1;
            end else begin
              i_rdata  <= m_rdata;
              i_rvalid <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xgriscv_memarb.sv
// Random-traffic bench for xgriscv_memarb at MEM_LAT 2, 1 and 15 against a cycle-schedule model.
module tb_xgriscv_memarb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns a distinct word every cycle so a wrong capture cycle shows up.
  function automatic logic [31:0] mem_word(int c);
    return (32'(c) * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  logic [31:0] m_rdata;
  assign m_rdata = mem_word(cyc);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    xgriscv_memarb #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(Lat)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_gnt   (i_gnt),
      .i_rvalid(i_rvalid),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_be    (d_be),
      .d_gnt   (d_gnt),
      .d_rvalid(d_rvalid),
      .d_rdata (d_rdata),
      .m_en    (m_en),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_be    (m_be),
      .m_rdata (m_rdata),
      .busy    (busy)
    );

    // Model: a schedule of cycle numbers derived from the timing rules.
    int          free_at = 0, issue_cyc = -1, rv_cyc = -1;
    bit          issue_own = 0, issue_we = 0, rv_own = 0, last_own = 0, own;
    bit          i_taken = 0, d_taken = 0;
    logic [31:0] rv_data = '0, e_irdata = '0, e_drdata = '0, e_addr = '0, e_wdata = '0;
    logic [3:0]  e_be = '0;
    logic [6:0]  e_ctl, o_ctl;

    always @(negedge clk) begin
      i_taken = (cyc == issue_cyc) && !issue_own;
      d_taken = (cyc == issue_cyc) && issue_own;
      if (cyc == rv_cyc) begin
        if (rv_own) e_drdata = rv_data;
        else e_irdata = rv_data;
      end
      if (started) begin
        e_ctl = {i_taken, d_taken, cyc == issue_cyc, (cyc == issue_cyc) && issue_we,
                 (cyc == rv_cyc) && !rv_own, (cyc == rv_cyc) && rv_own, cyc < free_at};
        o_ctl = {i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid, busy};
        check($sformatf("lat%0d.ctl@%0d", Lat, cyc), 64'(o_ctl), 64'(e_ctl));
        check($sformatf("lat%0d.i_rdata@%0d", Lat, cyc), 64'(i_rdata), 64'(e_irdata));
        check($sformatf("lat%0d.d_rdata@%0d", Lat, cyc), 64'(d_rdata), 64'(e_drdata));
        check($sformatf("lat%0d.m_addr@%0d", Lat, cyc), 64'(m_addr), 64'(e_addr));
        check($sformatf("lat%0d.m_wdata@%0d", Lat, cyc), 64'(m_wdata), 64'(e_wdata));
        check($sformatf("lat%0d.m_be@%0d", Lat, cyc), 64'(m_be), 64'(e_be));
      end
      if (reset) begin
        free_at   = cyc + 1;
        issue_cyc = -1;
        rv_cyc    = -1;
        e_irdata  = '0;
        e_drdata  = '0;
        e_addr    = '0;
        e_wdata   = '0;
        e_be      = '0;
        last_own  = 0;
      end else if (cyc >= free_at && (i_req || d_req)) begin
`ifdef XGRISCV_ARB_RR_EN
        own = (i_req && d_req) ? !last_own : d_req;
`else
        own = d_req;
`endif
        issue_cyc = cyc + 1;
        issue_own = own;
        issue_we  = own && d_we;
        last_own  = own;
        e_addr    = own ? d_addr : i_addr;
        if (own) begin
          e_wdata = d_wdata;
          e_be    = d_be;
        end
        if (issue_we) begin
          free_at = cyc + 2;
        end else begin
          free_at = cyc + 2 + int'(Lat);
          rv_cyc  = free_at;
          rv_own  = own;
          rv_data = mem_word(cyc + 1 + int'(Lat));
        end
      end
    end

    // Requesters hold a request until granted, then maybe issue a fresh one.
    always @(posedge clk) begin
      #1;
      if (!i_req || i_taken) begin
        i_req  = ($urandom_range(0, 99) < 55);
        i_addr = $urandom();
      end
      if (!d_req || d_taken) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom();
        d_wdata = $urandom();
        d_be    = 4'($urandom_range(0, 15));
      end
    end
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1 started = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3000) begin
      @(posedge clk);
      #1 reset = ($urandom_range(0, 149) == 0);
    end
    reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
